// File: rtl/line_clear_engine_if.sv
// Matrix memory port bundle between the line-clear engine (master) and the playfield memory (slave).
// Read data is combinational from the read address; writes commit on the clock edge.
interface line_clear_engine_if #(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
);
  localparam int unsigned AddrW = $clog2(height_p);

  logic [AddrW-1:0]   mm_read_addr_o;
  logic [width_p-1:0] mm_read_data_i;
  logic [AddrW-1:0]   mm_write_addr_o;
  logic [width_p-1:0] mm_write_data_o;
  logic               mm_write_v_o;

  modport master (
    output mm_read_addr_o,
    input  mm_read_data_i,
    output mm_write_addr_o,
    output mm_write_data_o,
    output mm_write_v_o
  );

  modport slave (
    input  mm_read_addr_o,
    output mm_read_data_i,
    input  mm_write_addr_o,
    input  mm_write_data_o,
    input  mm_write_v_o
  );
endinterface

// File: rtl/line_clear_engine.sv
// Single-pass bottom-up line clear: drops full rows, compacts survivors downward and
// zero-fills the vacated top rows, reporting cleared count and per-row mask.
module line_clear_engine #(
  parameter int unsigned width_p      = 16,
  parameter int unsigned height_p     = 32,
  parameter bit          early_exit_p = 1'b1,
  parameter bit          debug_p      = 1'b0,
  localparam int unsigned AddrW       = $clog2(height_p),
  localparam int unsigned CntW        = $clog2(height_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                v_i,
  output logic                ready_o,
  output logic                done_o,
  line_clear_engine_if.master mm,
  output logic [CntW-1:0]     cleared_count_o,
  output logic [height_p-1:0] cleared_mask_o
);

  typedef enum logic [1:0] {StIdle, StScan, StFill, StDone} state_e;

  localparam logic [AddrW-1:0] TopRow = AddrW'(height_p - 1);

  state_e              state_q;
  logic [AddrW-1:0]    rd_q;
  logic [AddrW-1:0]    wr_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     fill_q;
  logic [height_p-1:0] mask_q;
  logic                ready_q;
  logic                done_q;

  logic            row_full;
  logic            row_zero;
  logic            scan_last;
  logic [CntW-1:0] cnt_incl;

  always_comb begin
    row_full  = &mm.mm_read_data_i;
    row_zero  = ~|mm.mm_read_data_i;
    cnt_incl  = cnt_q + CntW'(row_full);
    // A full row can never be zero, so a full row never triggers early exit.
    scan_last = (rd_q == '0) || (early_exit_p && row_zero);
  end

  assign mm.mm_read_addr_o  = rd_q;
  assign mm.mm_write_addr_o = wr_q;
  assign mm.mm_write_data_o = (state_q == StFill) ? '0 : mm.mm_read_data_i;
  assign mm.mm_write_v_o    = ((state_q == StScan) && !row_full && (wr_q != rd_q)) ||
                              (state_q == StFill);

  assign ready_o         = ready_q;
  assign done_o          = done_q;
  assign cleared_count_o = cnt_q;
  assign cleared_mask_o  = mask_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      rd_q    <= TopRow;
      wr_q    <= TopRow;
      cnt_q   <= '0;
      fill_q  <= '0;
      mask_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (v_i) begin
            rd_q    <= TopRow;
            wr_q    <= TopRow;
            cnt_q   <= '0;
            mask_q  <= '0;
            ready_q <= 1'b0;
            state_q <= StScan;
          end
        end
        StScan: begin
          rd_q <= rd_q - AddrW'(1);
          if (row_full) begin
            mask_q[rd_q] <= 1'b1;
            cnt_q        <= cnt_incl;
          end else begin
            wr_q <= wr_q - AddrW'(1);
          end
          if (scan_last) begin
            if (cnt_incl != '0) begin
              fill_q  <= cnt_incl;
              state_q <= StFill;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StFill: begin
          // wr_q may wrap after the final fill write; it is reloaded before any further use.
          wr_q   <= wr_q - AddrW'(1);
          fill_q <= fill_q - CntW'(1);
          if (fill_q == CntW'(1)) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  if (debug_p) begin : g_debug
    always_ff @(posedge clk_i) begin
      if (!reset_i && (state_q == StFill)) begin
        assert (fill_q != '0)
          else $error("line_clear_engine: fill entered with zero remaining writes");
      end
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: vector table plus model-driven random matrices, with a
// scoreboard of expected results checked at done_o, and hand-written reset/start corners.
module tb_line_clear_engine;

  localparam int unsigned W = 16;
  localparam int unsigned H = 8;

  typedef logic [H-1:0][W-1:0] mat_t;

  typedef struct {
    bit         ee;
    mat_t       init;
    int         cnt;
    logic [7:0] mask;
    int         lat;
    mat_t       fin;
  } vec_t;

  typedef struct {
    bit         ee;
    int         cnt;
    logic [7:0] mask;
    int         lat;
    mat_t       fin;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic load0 = 1'b0, load1 = 1'b0;
  logic sel_r = 1'b0;
  mat_t init_mem = '0;
  mat_t mem0, mem1;
  int   cyc = 0;

  logic       ready0, ready1, done0, done1;
  logic [3:0] cnt0, cnt1;
  logic [7:0] mask0, mask1;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_clear_engine_if #(.width_p(W), .height_p(H)) mm0 ();
  line_clear_engine_if #(.width_p(W), .height_p(H)) mm1 ();

  line_clear_engine #(.width_p(W), .height_p(H), .early_exit_p(1'b0), .debug_p(1'b1)) dut0 (
    .clk_i(clk), .reset_i(rst), .v_i(v0), .ready_o(ready0), .done_o(done0), .mm(mm0),
    .cleared_count_o(cnt0), .cleared_mask_o(mask0)
  );

  line_clear_engine #(.width_p(W), .height_p(H), .early_exit_p(1'b1), .debug_p(1'b1)) dut1 (
    .clk_i(clk), .reset_i(rst), .v_i(v1), .ready_o(ready1), .done_o(done1), .mm(mm1),
    .cleared_count_o(cnt1), .cleared_mask_o(mask1)
  );

  assign mm0.mm_read_data_i = mem0[mm0.mm_read_addr_o];
  assign mm1.mm_read_data_i = mem1[mm1.mm_read_addr_o];

  always @(posedge clk) begin
    if (load0) mem0 <= init_mem;
    else if (mm0.mm_write_v_o) mem0[mm0.mm_write_addr_o] <= mm0.mm_write_data_o;
  end

  always @(posedge clk) begin
    if (load1) mem1 <= init_mem;
    else if (mm1.mm_write_v_o) mem1[mm1.mm_write_addr_o] <= mm1.mm_write_data_o;
  end

  logic       cur_ready, cur_done;
  logic [3:0] cur_cnt;
  logic [7:0] cur_mask;
  mat_t       cur_mem;
  assign cur_ready = sel_r ? ready1 : ready0;
  assign cur_done  = sel_r ? done1  : done0;
  assign cur_cnt   = sel_r ? cnt1   : cnt0;
  assign cur_mask  = sel_r ? mask1  : mask0;
  assign cur_mem   = sel_r ? mem1   : mem0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour without early exit: keep non-full rows in bottom-up order.
  function automatic exp_t model(input mat_t m);
    exp_t e;
    int   k;
    e.ee   = 1'b0;
    e.cnt  = 0;
    e.mask = '0;
    e.fin  = '0;
    k      = H - 1;
    for (int r = H - 1; r >= 0; r--) begin
      if (m[r] == {W{1'b1}}) begin
        e.cnt++;
        e.mask[r] = 1'b1;
      end else begin
        e.fin[k] = m[r];
        k--;
      end
    end
    e.lat = H + e.cnt + 1;
    return e;
  endfunction

  task automatic load_mat(input bit ee, input mat_t m);
    sel_r    = ee;
    init_mem = m;
    @(negedge clk);
    if (ee) load1 = 1'b1; else load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic run_op(input exp_t e, input mat_t m, input string tag);
    int   t0;
    bit   seen;
    exp_t got;
    load_mat(e.ee, m);
    if (e.ee) v1 = 1'b1; else v0 = 1'b1;
    t0 = cyc;
    sbq.push_back(e);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * H + 8; i++) begin
      @(negedge clk);
      if (cur_done) begin
        seen = 1'b1;
        break;
      end
    end
    got = sbq.pop_front();
    if (!seen) begin
      check({tag, " done timeout"}, 128'(0), 128'(1));
    end else begin
      check({tag, " latency"}, 128'(cyc - t0), 128'(got.lat));
      check({tag, " count"},   128'(cur_cnt),  128'(got.cnt));
      check({tag, " mask"},    128'(cur_mask), 128'(got.mask));
      check({tag, " memory"},  128'(cur_mem),  128'(got.fin));
      @(negedge clk);
      check({tag, " ready after done"}, 128'({cur_ready, cur_done}), 128'(2'b10));
    end
  endtask

  vec_t vecs[9];

  initial begin
    exp_t e;
    mat_t m;

    vecs[0] = '{1'b0, '0, 0, 8'h00, 9, '0};
    vecs[1] = '{1'b0, {16'hFFFF, 16'h00F0, {6{16'h0000}}}, 1, 8'h80, 10,
                {16'h00F0, {7{16'h0000}}}};
    vecs[2] = '{1'b0, {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0100, {4{16'h0000}}}, 2, 8'hA0, 11,
                {16'h0001, 16'h0100, {6{16'h0000}}}};
    vecs[3] = '{1'b1, {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0100, {4{16'h0000}}}, 2, 8'hA0, 8,
                {16'h0001, 16'h0100, {6{16'h0000}}}};
    vecs[4] = '{1'b0, {8{16'hFFFF}}, 8, 8'hFF, 17, '0};
    vecs[5] = '{1'b0, {16'h1234, {3{16'h0000}}, 16'h8000, {2{16'h0000}}, 16'hFFFF}, 1, 8'h01, 10,
                {16'h1234, {3{16'h0000}}, 16'h8000, {3{16'h0000}}}};
    vecs[6] = '{1'b1, {16'h1234, {3{16'h0000}}, 16'h8000, {2{16'h0000}}, 16'hFFFF}, 0, 8'h00, 3,
                {16'h1234, {3{16'h0000}}, 16'h8000, {2{16'h0000}}, 16'hFFFF}};
    vecs[7] = '{1'b1, {16'hFFFF, {7{16'h0000}}}, 1, 8'h80, 4, '0};
    vecs[8] = '{1'b1, {16'h0000, 16'hFFFF, {6{16'h0000}}}, 0, 8'h00, 2,
                {16'h0000, 16'hFFFF, {6{16'h0000}}}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ready/done", 128'({ready0, done0, ready1, done1}), 128'(4'b1010));
    check("reset count/mask", 128'({cnt0, mask0, cnt1, mask1}), 128'(0));
    check("reset write_v", 128'({mm0.mm_write_v_o, mm1.mm_write_v_o}), 128'(0));
    check("reset addresses", 128'({mm0.mm_read_addr_o, mm0.mm_write_addr_o,
                                   mm1.mm_read_addr_o, mm1.mm_write_addr_o}),
          128'({4{3'd7}}));

    for (int i = 0; i < 9; i++) begin
      e.ee   = vecs[i].ee;
      e.cnt  = vecs[i].cnt;
      e.mask = vecs[i].mask;
      e.lat  = vecs[i].lat;
      e.fin  = vecs[i].fin;
      run_op(e, vecs[i].init, $sformatf("vec%0d", i));
    end

    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < H; r++)
        m[r] = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      run_op(model(m), m, $sformatf("rand%0d", n));
    end

    // Reset in the third scan cycle, with a stray start during scan.
    load_mat(1'b0, {16'hFFFF, 16'hFFFF, 16'h0F0F, {5{16'h0000}}});
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    check("mid-scan count/mask", 128'({cnt0, mask0}), 128'({4'd2, 8'hC0}));
    check("mid-scan no restart", 128'({ready0, mm0.mm_read_addr_o}), 128'({1'b0, 3'd5}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post-reset ready/done", 128'({ready0, done0}), 128'(2'b10));
    check("post-reset count/mask", 128'({cnt0, mask0}), 128'(0));
    check("post-reset outputs", 128'({mm0.mm_write_v_o, mm0.mm_read_addr_o, mm0.mm_write_addr_o}),
          128'({1'b0, 3'd7, 3'd7}));
    @(negedge clk);
    check("post-reset idle hold", 128'({ready0, mm0.mm_write_v_o}), 128'(2'b10));

    m = {16'h00FF, 16'hFFFF, 16'hFFFF, 16'h0001, {4{16'h0000}}};
    run_op(model(m), m, "recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
